// File: rtl/pc_branch_ctrl.sv
`default_nettype none
//=============================================================================
// Module      : pc_branch_ctrl
// Description : Program-sequencing stage behind the accumulator ALU.
//               Registers the ALU z/neg flags, resolves BRZ/BRN/JMP against
//               the registered flags using a writable absolute-target LUT,
//               drives the instruction-fetch PC and runs the start/done
//               program handshake (IDLE -> RUN -> HALT).
//               Optional build macro BR_STATS_EN adds cyc_cnt/taken_cnt
//               statistics outputs (16-bit, saturating).
// Revision    : 1.0 - initial release
//=============================================================================
module pc_branch_ctrl #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_i,
  input  logic [1:0]        br_op,
  input  logic [LUT_AW-1:0] br_idx,
  input  logic              flag_we,
  input  logic              z_in,
  input  logic              neg_in,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              done,
  output logic              z_flag,
  output logic              neg_flag
`ifdef BR_STATS_EN
  ,
  output logic [15:0]       cyc_cnt,
  output logic [15:0]       taken_cnt
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_lut_depth = 1 << LUT_AW;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_halt = 2'd2;

  localparam logic [1:0] c_br_none = 2'b00;
  localparam logic [1:0] c_br_brz  = 2'b01;
  localparam logic [1:0] c_br_brn  = 2'b10;
  localparam logic [1:0] c_br_jmp  = 2'b11;

  localparam logic [PC_W-1:0] c_pc_zero = '0;
  localparam logic [PC_W-1:0] c_pc_one  = {{(PC_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_running;
  logic            r_done;
  logic            r_z_flag;
  logic            r_neg_flag;
  logic [PC_W-1:0] r_lut [c_lut_depth];

  logic            w_taken;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_in_run;

  // The LUT read is combinational on the pre-edge contents, so a write to the
  // same entry in the same cycle is only seen by branches from the next cycle.
  assign w_target = r_lut[br_idx];
  // Natural PC_W-bit rollover gives the silent wrap from all-ones to zero.
  assign w_pc_inc = r_pc + c_pc_one;
  assign w_in_run = (r_state == c_st_run);

  // Branch resolution against the registered flags only.
  always_comb begin
    w_taken = 1'b0;
    case (br_op)
      c_br_none: w_taken = 1'b0;
      c_br_brz:  w_taken = r_z_flag;
      c_br_brn:  w_taken = r_neg_flag;
      c_br_jmp:  w_taken = 1'b1;
      default:   w_taken = 1'b0;
    endcase
  end

  // Sequencer FSM and program counter; start restarts from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_st_idle;
      r_pc      <= c_pc_zero;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else if (start) begin
      r_state   <= c_st_run;
      r_pc      <= c_pc_zero;
      r_running <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          r_pc <= c_pc_zero;
        end
        c_st_run: begin
          if (halt_i) begin
            r_state   <= c_st_halt;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else if (w_taken) begin
            r_pc <= w_target;
          end else begin
            r_pc <= w_pc_inc;
          end
        end
        c_st_halt: begin
          r_state <= c_st_halt;
        end
        default: begin
          // Unreachable encoding: fall back to a clean idle.
          r_state   <= c_st_idle;
          r_pc      <= c_pc_zero;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  // ALU flag capture: only while running, cleared whenever a start is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_z_flag   <= 1'b0;
      r_neg_flag <= 1'b0;
    end else if (start) begin
      r_z_flag   <= 1'b0;
      r_neg_flag <= 1'b0;
    end else if (flag_we && w_in_run) begin
      r_z_flag   <= z_in;
      r_neg_flag <= neg_in;
    end
  end

  // Branch-target table: written in any state, wiped by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_lut_depth; i++) begin
        r_lut[i] <= c_pc_zero;
      end
    end else if (lut_we) begin
      r_lut[lut_waddr] <= lut_wdata;
    end
  end

  assign pc       = r_pc;
  assign running  = r_running;
  assign done     = r_done;
  assign z_flag   = r_z_flag;
  assign neg_flag = r_neg_flag;

`ifdef BR_STATS_EN
  localparam logic [15:0] c_cnt_max = 16'hFFFF;
  localparam logic [15:0] c_cnt_one = 16'h0001;

  logic [15:0] r_cyc_cnt;
  logic [15:0] r_taken_cnt;
  logic        w_br_taken_evt;

  // A branch only counts when it actually redirects the PC (halt wins).
  assign w_br_taken_evt = w_in_run && !start && !halt_i && w_taken;

  // Saturating RUN-cycle and taken-branch counters, cleared on start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc_cnt   <= '0;
      r_taken_cnt <= '0;
    end else if (start) begin
      r_cyc_cnt   <= '0;
      r_taken_cnt <= '0;
    end else begin
      if (w_in_run && (r_cyc_cnt != c_cnt_max)) begin
        r_cyc_cnt <= r_cyc_cnt + c_cnt_one;
      end
      if (w_br_taken_evt && (r_taken_cnt != c_cnt_max)) begin
        r_taken_cnt <= r_taken_cnt + c_cnt_one;
      end
    end
  end

  assign cyc_cnt   = r_cyc_cnt;
  assign taken_cnt = r_taken_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_ctrl.sv
`default_nettype none
//=============================================================================
// Module      : tb_pc_branch_ctrl
// Description : Self-checking bench for pc_branch_ctrl. Directed scenarios
//               followed by randomized traffic, every cycle compared against
//               a behavioural model of the sequencer rules.
// Revision    : 1.0 - initial release
//=============================================================================
module tb_pc_branch_ctrl;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 4;
  localparam int DEPTH  = 1 << LUT_AW;
  localparam int PC_MOD = 1 << PC_W;

  logic              clk;
  logic              reset;
  logic              start;
  logic              halt_i;
  logic [1:0]        br_op;
  logic [LUT_AW-1:0] br_idx;
  logic              flag_we;
  logic              z_in;
  logic              neg_in;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic              running;
  logic              done;
  logic              z_flag;
  logic              neg_flag;
`ifdef BR_STATS_EN
  logic [15:0]       cyc_cnt;
  logic [15:0]       taken_cnt;
`endif

  pc_branch_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .halt_i    (halt_i),
    .br_op     (br_op),
    .br_idx    (br_idx),
    .flag_we   (flag_we),
    .z_in      (z_in),
    .neg_in    (neg_in),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata),
    .pc        (pc),
    .running   (running),
    .done      (done),
    .z_flag    (z_flag),
    .neg_flag  (neg_flag)
`ifdef BR_STATS_EN
    ,
    .cyc_cnt   (cyc_cnt),
    .taken_cnt (taken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: program status as plain integers and an array of targets.
  int m_pc;
  bit m_run;
  bit m_done;
  bit m_z;
  bit m_n;
  int m_lut [DEPTH];
  int m_cyc;
  int m_taken;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},      32'(pc),       32'(m_pc));
    check({tag, ".running"}, 32'(running),  32'(m_run));
    check({tag, ".done"},    32'(done),     32'(m_done));
    check({tag, ".z"},       32'(z_flag),   32'(m_z));
    check({tag, ".neg"},     32'(neg_flag), 32'(m_n));
`ifdef BR_STATS_EN
    check({tag, ".cyc"},     32'(cyc_cnt),   32'(m_cyc));
    check({tag, ".taken"},   32'(taken_cnt), 32'(m_taken));
`endif
  endtask

  task automatic model_reset();
    m_pc = 0; m_run = 0; m_done = 0; m_z = 0; m_n = 0; m_cyc = 0; m_taken = 0;
    for (int i = 0; i < DEPTH; i++) m_lut[i] = 0;
  endtask

  // One clock of the sequencing rules, evaluated from the current inputs.
  task automatic model_step();
    int tgt;
    bit tk;
    tgt = m_lut[br_idx];
    tk  = (br_op == 2'b11) || (br_op == 2'b01 && m_z) || (br_op == 2'b10 && m_n);
    if (start) begin
      m_run = 1; m_done = 0; m_pc = 0; m_z = 0; m_n = 0; m_cyc = 0; m_taken = 0;
    end else if (m_run) begin
      if (m_cyc < 65535) m_cyc++;
      if (flag_we) begin m_z = z_in; m_n = neg_in; end
      if (halt_i) begin
        m_run = 0; m_done = 1;
      end else if (tk) begin
        m_pc = tgt;
        if (m_taken < 65535) m_taken++;
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
  endtask

  task automatic idle_inputs();
    start = 0; halt_i = 0; br_op = 2'b00; br_idx = '0; flag_we = 0;
    z_in = 0; neg_in = 0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic lut_write(input int idx, input int data);
    lut_we = 1; lut_waddr = LUT_AW'(idx); lut_wdata = PC_W'(data);
    step("lutw");
    lut_we = 0;
  endtask

  task automatic do_start();
    start = 1;
    step("start");
    start = 0;
  endtask

  task automatic run_to_pc(input int target);
    int n;
    n = 0;
    while (m_pc != target && n < 2 * PC_MOD) begin
      step("adv");
      n++;
    end
    check("run_to_pc.reached", 32'(pc), 32'(target));
  endtask

  int held_pc;

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.pc_const", 32'(pc), 32'd0);
    reset = 0;
    step("idle_hold");

    // Straight-line program: 0,1,2,3,4.
    do_start();
    check("seq.pc0", 32'(pc), 32'd0);
    for (int i = 1; i < 5; i++) begin
      step("seq");
      check("seq.pc_const", 32'(pc), 32'(i));
    end
    check("seq.running", 32'(running), 32'd1);
    check("seq.done", 32'(done), 32'd0);

    // JMP via LUT[3]=0x040 from pc=7.
    lut_write(3, 'h040);
    run_to_pc(7);
    br_op = 2'b11; br_idx = 4'd3;
    step("jmp");
    br_op = 2'b00;
    check("jmp.pc_const", 32'(pc), 32'h040);

    // BRZ taken after z latched one cycle earlier.
    do_start();
    lut_write(1, 'h010);
    run_to_pc(2);
    flag_we = 1; z_in = 1;
    step("brz_flag1");
    flag_we = 0; z_in = 0;
    br_op = 2'b01; br_idx = 4'd1;
    step("brz_taken");
    br_op = 2'b00;
    check("brz.taken_const", 32'(pc), 32'h010);

    // Same program with z_in=0: falls through to 4.
    do_start();
    run_to_pc(2);
    flag_we = 1; z_in = 0;
    step("brz_flag0");
    flag_we = 0;
    br_op = 2'b01; br_idx = 4'd1;
    step("brz_not");
    br_op = 2'b00;
    check("brz.fall_const", 32'(pc), 32'd4);

    // BRZ in the same cycle as flag_we must see the old (zero) flag.
    held_pc = m_pc;
    flag_we = 1; z_in = 1; br_op = 2'b01; br_idx = 4'd1;
    step("brz_same");
    flag_we = 0; z_in = 0;
    check("brz_same.pc_const", 32'(pc), 32'(held_pc + 1));
    check("brz_same.z_const", 32'(z_flag), 32'd1);
    step("brz_next");
    br_op = 2'b00;
    check("brz_next.pc_const", 32'(pc), 32'h010);

    // Same-cycle LUT write and branch read: old entry used.
    lut_we = 1; lut_waddr = 4'd1; lut_wdata = 10'h155; br_op = 2'b11; br_idx = 4'd1;
    step("lut_bypass");
    lut_we = 0;
    check("lut_bypass.old", 32'(pc), 32'h010);
    step("lut_new");
    br_op = 2'b00;
    check("lut_new.pc", 32'(pc), 32'h155);

    // neg latched, then halt together with BRN: halt wins, pc holds.
    flag_we = 1; neg_in = 1;
    step("neg_latch");
    flag_we = 0; neg_in = 0;
    held_pc = m_pc;
    halt_i = 1; br_op = 2'b10; br_idx = 4'd3;
    step("halt");
    halt_i = 0; br_op = 2'b00;
    check("halt.pc_const", 32'(pc), 32'(held_pc));
    check("halt.done_const", 32'(done), 32'd1);
    // Everything but start is ignored in HALT.
    flag_we = 1; z_in = 1; neg_in = 0; br_op = 2'b11; halt_i = 1;
    repeat (3) step("halt_hold");
    idle_inputs();
    check("halt_hold.pc_const", 32'(pc), 32'(held_pc));
    do_start();
    check("restart.done_const", 32'(done), 32'd0);
    check("restart.neg_const", 32'(neg_flag), 32'd0);

    // Wrap from 0x3FF to 0.
    lut_write(5, 'h3FF);
    br_op = 2'b11; br_idx = 4'd5;
    step("jmp_top");
    br_op = 2'b00;
    check("wrap.top_const", 32'(pc), 32'h3FF);
    step("wrap");
    check("wrap.zero_const", 32'(pc), 32'd0);

    // Asynchronous reset mid-RUN, no clock edge needed.
    step("pre_reset");
    #2;
    reset = 1;
    #1;
    model_reset();
    check_all("async_reset");
    check("async_reset.pc_const", 32'(pc), 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
    do_start();
    br_op = 2'b11; br_idx = 4'd3;
    step("lut_cleared");
    br_op = 2'b00;
    check("lut_cleared.pc_const", 32'(pc), 32'd0);

`ifdef BR_STATS_EN
    // 10 RUN cycles with 3 taken JMPs.
    lut_write(2, 'h020);
    do_start();
    for (int i = 0; i < 10; i++) begin
      br_op = (i == 1 || i == 4 || i == 8) ? 2'b11 : 2'b00;
      br_idx = 4'd2;
      step("stats");
    end
    br_op = 2'b00;
    check("stats.cyc_const", 32'(cyc_cnt), 32'd10);
    check("stats.taken_const", 32'(taken_cnt), 32'd3);
    halt_i = 1;
    step("stats_halt");
    halt_i = 0;
    br_op = 2'b11;
    repeat (3) step("stats_hold");
    br_op = 2'b00;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      start     = ($urandom_range(0, 24) == 0);
      halt_i    = ($urandom_range(0, 29) == 0);
      br_op     = 2'($urandom_range(0, 3));
      br_idx    = LUT_AW'($urandom_range(0, DEPTH - 1));
      flag_we   = 1'($urandom_range(0, 1));
      z_in      = 1'($urandom_range(0, 1));
      neg_in    = 1'($urandom_range(0, 1));
      lut_we    = ($urandom_range(0, 2) == 0);
      lut_waddr = LUT_AW'($urandom_range(0, DEPTH - 1));
      lut_wdata = PC_W'($urandom_range(0, PC_MOD - 1));
      step("rand");
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
